// File: rtl/pc_tx_word_serialiser.sv
// Word FIFO feeding a byte serialiser: buffers 32-bit router words and launches
// them MSB first, one byte at a time, through a start/active UART handshake.
module pc_tx_word_serialiser #(
    parameter int FIFO_DEPTH = 4,
    parameter int CW         = $clog2(FIFO_DEPTH) + 1
) (
    input  logic          i_clock,
    input  logic          i_reset,
    input  logic [31:0]   i_word,
    input  logic          i_word_valid,
    output logic          o_busy,
    output logic [CW-1:0] o_fifo_count,
    output logic          o_overflow,
    output logic [7:0]    o_tx_byte,
    output logic          o_tx_byte_start,
    input  logic          i_tx_active,
    output logic          o_idle,
    output logic [15:0]   o_words_sent
);
    localparam int            PW         = $clog2(FIFO_DEPTH);
    localparam logic [CW-1:0] FULL_COUNT = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        SEND      = 2'd1,
        WAIT_ACK  = 2'd2,
        WAIT_DONE = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [31:0]   mem_q [FIFO_DEPTH];
    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    logic          overflow_q, overflow_d;
    logic [31:0]   shift_q, shift_d;
    logic [1:0]    byte_idx_q, byte_idx_d;
    logic [7:0]    tx_byte_q, tx_byte_d;
    logic          start_q, start_d;
    logic [15:0]   words_sent_q, words_sent_d;

    logic full;
    logic push_ok;
    logic pop;

    assign full    = (count_q == FULL_COUNT);
    assign push_ok = i_word_valid && !full;
    assign pop     = (state_q == IDLE) && (count_q != '0);

    // A write that meets a full FIFO is lost even if a pop frees a slot on the same edge.
    always_comb begin
        tail_d     = tail_q;
        count_d    = count_q;
        overflow_d = overflow_q;

        if (i_word_valid && full) begin
            overflow_d = 1'b1;
        end
        if (push_ok) begin
            tail_d = tail_q + PW'(1);
        end
        case ({push_ok, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        head_d       = head_q;
        shift_d      = shift_q;
        byte_idx_d   = byte_idx_q;
        tx_byte_d    = tx_byte_q;
        start_d      = 1'b0;
        words_sent_d = words_sent_q;

        case (state_q)
            IDLE: begin
                if (pop) begin
                    shift_d    = mem_q[head_q];
                    head_d     = head_q + PW'(1);
                    byte_idx_d = 2'd0;
                    state_d    = SEND;
                end
            end
            SEND: begin
                if (!i_tx_active) begin
                    tx_byte_d = shift_q[31:24];
                    start_d   = 1'b1;
                    state_d   = WAIT_ACK;
                end
            end
            WAIT_ACK: begin
                // No timeout: a silent transmitter holds the block here.
                if (i_tx_active) begin
                    state_d = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (!i_tx_active) begin
                    if (byte_idx_q == 2'd3) begin
                        words_sent_d = words_sent_q + 16'd1;
                        state_d      = IDLE;
                    end else begin
                        shift_d    = {shift_q[23:0], 8'h00};
                        byte_idx_d = byte_idx_q + 2'd1;
                        state_d    = SEND;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            state_q      <= IDLE;
            head_q       <= '0;
            tail_q       <= '0;
            count_q      <= '0;
            overflow_q   <= 1'b0;
            shift_q      <= '0;
            byte_idx_q   <= 2'd0;
            tx_byte_q    <= 8'h00;
            start_q      <= 1'b0;
            words_sent_q <= 16'd0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            head_q       <= head_d;
            tail_q       <= tail_d;
            count_q      <= count_d;
            overflow_q   <= overflow_d;
            shift_q      <= shift_d;
            byte_idx_q   <= byte_idx_d;
            tx_byte_q    <= tx_byte_d;
            start_q      <= start_d;
            words_sent_q <= words_sent_d;
            if (push_ok) begin
                mem_q[tail_q] <= i_word;
            end
        end
    end

    assign o_busy          = full;
    assign o_fifo_count    = count_q;
    assign o_overflow      = overflow_q;
    assign o_tx_byte       = tx_byte_q;
    assign o_tx_byte_start = start_q;
    assign o_idle          = (state_q == IDLE) && (count_q == '0);
    assign o_words_sent    = words_sent_q;

endmodule

// File: tb/tb_pc_tx_word_serialiser.sv
// Scoreboard bench: writes queue the expected byte stream; a monitor pops and
// compares on every start pulse while a UART model answers the handshake.
module tb_pc_tx_word_serialiser;
    localparam int FIFO_DEPTH = 4;
    localparam int CW         = $clog2(FIFO_DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst;
    logic [31:0]   i_word;
    logic          i_word_valid;
    logic          i_tx_active;
    logic          o_busy;
    logic [CW-1:0] o_fifo_count;
    logic          o_overflow;
    logic [7:0]    o_tx_byte;
    logic          o_tx_byte_start;
    logic          o_idle;
    logic [15:0]   o_words_sent;

    int         n_cmp = 0;
    int         n_err = 0;
    int         start_cnt = 0;
    int         exp_ws = 0;
    logic [7:0] exp_q[$];
    int         hold_len = 10;
    bit         rand_hold = 1'b0;
    bit         force_busy = 1'b0;
    bit         manual_act = 1'b0;
    bit         stall_mode = 1'b0;

    always #5 clk = ~clk;

    pc_tx_word_serialiser #(.FIFO_DEPTH(FIFO_DEPTH)) dut (
        .i_clock         (clk),
        .i_reset         (rst),
        .i_word          (i_word),
        .i_word_valid    (i_word_valid),
        .o_busy          (o_busy),
        .o_fifo_count    (o_fifo_count),
        .o_overflow      (o_overflow),
        .o_tx_byte       (o_tx_byte),
        .o_tx_byte_start (o_tx_byte_start),
        .i_tx_active     (i_tx_active),
        .o_idle          (o_idle),
        .o_words_sent    (o_words_sent)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end else begin
            $display("ok   %s: 0x%0h", name, act);
        end
    endtask

    // Reference: an accepted word becomes four bytes, most significant first.
    task automatic put(input logic [31:0] w, input bit accept);
        i_word       = w;
        i_word_valid = 1'b1;
        if (accept) begin
            for (int k = 3; k >= 0; k--) exp_q.push_back(w[8*k +: 8]);
            exp_ws++;
        end
        @(negedge clk);
        i_word_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int bound);
        int n = 0;
        while (!o_idle && n < bound) begin
            @(negedge clk);
            n++;
        end
        check(name, {31'd0, o_idle}, 32'd1);
    endtask

    task automatic wait_starts(input string name, input int target, input int bound);
        int n = 0;
        while (start_cnt < target && n < bound) begin
            @(negedge clk);
            n++;
        end
        check(name, start_cnt, target);
    endtask

    // UART model: acknowledges a start one cycle later and stays active for hold cycles.
    initial begin
        int act_cnt = 0;
        i_tx_active = 1'b0;
        forever begin
            @(negedge clk);
            if (o_tx_byte_start && !stall_mode) begin
                act_cnt = rand_hold ? int'($urandom_range(1, 12)) : hold_len;
            end else if (act_cnt > 0) begin
                act_cnt--;
            end
            i_tx_active = force_busy || manual_act || (act_cnt > 0);
        end
    end

    initial begin
        logic [7:0] e;
        forever begin
            @(negedge clk);
            if (o_tx_byte_start) begin
                start_cnt++;
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_start: got byte 0x%0h, want no start", o_tx_byte);
                end else begin
                    e = exp_q.pop_front();
                    check("tx_byte", {24'd0, o_tx_byte}, {24'd0, e});
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout, want finish");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int s;
        logic [31:0] w;
        rst          = 1'b1;
        i_word       = '0;
        i_word_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy",     {31'd0, o_busy}, 0);
        check("rst_count",    {29'd0, o_fifo_count}, 0);
        check("rst_overflow", {31'd0, o_overflow}, 0);
        check("rst_tx_byte",  {24'd0, o_tx_byte}, 0);
        check("rst_start",    {31'd0, o_tx_byte_start}, 0);
        check("rst_idle",     {31'd0, o_idle}, 1);
        check("rst_words",    {16'd0, o_words_sent}, 0);
        rst = 1'b0;
        @(negedge clk);

        // Single word with latency of the first start pulse
        s = start_cnt;
        put(32'hA1B2C3D4, 1'b1);
        check("lat_after_e0", {31'd0, o_tx_byte_start}, 0);
        @(negedge clk);
        check("lat_after_e1", {31'd0, o_tx_byte_start}, 0);
        @(negedge clk);
        check("lat_after_e2", {31'd0, o_tx_byte_start}, 1);
        check("lat_byte", {24'd0, o_tx_byte}, 32'hA1);
        wait_idle("single_idle", 300);
        check("single_starts", start_cnt - s, 4);
        check("single_words", {16'd0, o_words_sent}, exp_ws);

        // Write on the pop edge: count holds at one
        put(32'h0BADF00D, 1'b1);
        put(32'hCAFE1234, 1'b1);
        check("pushpop_count", {29'd0, o_fifo_count}, 1);
        wait_idle("pushpop_idle", 600);
        check("pushpop_words", {16'd0, o_words_sent}, exp_ws);

        // Transmitter never acknowledges until released by hand
        stall_mode = 1'b1;
        s = start_cnt;
        put(32'h5A6B7C8D, 1'b1);
        wait_starts("stall_first", s + 1, 10);
        repeat (20) @(negedge clk);
        check("stall_no_start", start_cnt - s, 1);
        check("stall_not_idle", {31'd0, o_idle}, 0);
        manual_act = 1'b1;
        repeat (3) @(negedge clk);
        manual_act = 1'b0;
        stall_mode = 1'b0;
        wait_starts("stall_resume", s + 2, 10);
        wait_idle("stall_idle", 300);
        check("stall_words", {16'd0, o_words_sent}, exp_ws);

        // Stream ten distinct words through, wrapping the pointers
        rand_hold = 1'b1;
        for (int i = 0; i < 10; i++) begin
            int n = 0;
            while (o_busy && n < 600) begin
                @(negedge clk);
                n++;
            end
            if (o_busy) check("wrap_busy_timeout", {31'd0, o_busy}, 0);
            w = {8'(i + 1), 24'($urandom)};
            put(w, 1'b1);
            repeat ($urandom_range(0, 30)) @(negedge clk);
        end
        wait_idle("wrap_idle", 3000);
        check("wrap_words", {16'd0, o_words_sent}, exp_ws);
        check("wrap_no_overflow", {31'd0, o_overflow}, 0);
        rand_hold = 1'b0;

        // Fill and overflow: first word occupies the serialiser, next four fill the FIFO
        force_busy = 1'b1;
        repeat (2) @(negedge clk);
        put(32'hF0E1D2C3, 1'b1);
        repeat (3) @(negedge clk);
        for (int i = 1; i <= 4; i++) put(32'(i), 1'b1);
        check("fill_count", {29'd0, o_fifo_count}, FIFO_DEPTH);
        check("fill_busy", {31'd0, o_busy}, 1);
        check("fill_no_overflow_yet", {31'd0, o_overflow}, 0);
        put(32'd5, 1'b0);
        check("fill_overflow", {31'd0, o_overflow}, 1);
        check("fill_count_after_drop", {29'd0, o_fifo_count}, FIFO_DEPTH);
        force_busy = 1'b0;
        wait_idle("fill_idle", 2000);
        check("fill_overflow_sticky", {31'd0, o_overflow}, 1);
        check("fill_words", {16'd0, o_words_sent}, exp_ws);

        // Reset after the second byte with two words queued
        s = start_cnt;
        put(32'h11223344, 1'b1);
        put(32'h99AABBCC, 1'b1);
        put(32'hDDEEFF00, 1'b1);
        wait_starts("rstmid_two_bytes", s + 2, 100);
        repeat (2) @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("rstmid_count",    {29'd0, o_fifo_count}, 0);
        check("rstmid_busy",     {31'd0, o_busy}, 0);
        check("rstmid_overflow", {31'd0, o_overflow}, 0);
        check("rstmid_tx_byte",  {24'd0, o_tx_byte}, 0);
        check("rstmid_start",    {31'd0, o_tx_byte_start}, 0);
        check("rstmid_idle",     {31'd0, o_idle}, 1);
        check("rstmid_words",    {16'd0, o_words_sent}, 0);
        exp_q.delete();
        exp_ws = 0;
        s = start_cnt;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        repeat (30) @(negedge clk);
        check("rstmid_no_start", start_cnt - s, 0);
        check("rstmid_idle_after", {31'd0, o_idle}, 1);
        put(32'h55667788, 1'b1);
        wait_idle("post_rst_idle", 300);
        check("post_rst_starts", start_cnt - s, 4);
        check("post_rst_words", {16'd0, o_words_sent}, exp_ws);

        check("all_bytes_delivered", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
